mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_pkg.sv | 40 ++++
 rtl/mc_waitctr.sv | 27 ++
 rtl/mc_controller.sv | 162 ++++++++++++++++
 tb/tb_mc_controller.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes and datapath select codes.
// States 9/10 exist only when MC_ADDI_EN is defined; otherwise they decode as unused.
package mc_pkg;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecute  = 4'd6,
        StAluWb    = 4'd7,
        StBranch   = 4'd8,
        StAddiEx   = 4'd9,
        StAddiWb   = 4'd10,
        StJump     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

endpackage

// File: rtl/mc_waitctr.sv
// Memory wait counter: counts consecutive not-ready cycles while enabled and flags the
// cycle in which the count would reach TIMEOUT (ready in that cycle suppresses the flag).
module mc_waitctr #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_ready,
    output logic o_timeout
);

    logic [4:0] r_cnt;

    assign o_timeout = i_en && !i_ready && (r_cnt == 5'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (!i_en || i_ready || o_timeout) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 5'd1;
        end
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS-style control FSM (Moore) with memory-wait timeout and illegal-op detection.
// Define MC_ADDI_EN to enable the addi path (ADDIEX/ADDIWB); otherwise op 001000 is illegal.
module mc_controller #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       ALUSrcA,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       mem_err,
    output logic       illegal_op,
    output logic [3:0] state
);

    import mc_pkg::*;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_mem_state;
    logic   w_timeout;
    logic   w_illegal;

    assign w_mem_state = (r_state == StFetch) || (r_state == StMemRead) ||
                         (r_state == StMemWrite);

    mc_waitctr #(
        .TIMEOUT (TIMEOUT)
    ) u_waitctr (
        .clk       (clk),
        .reset     (reset),
        .i_en      (w_mem_state),
        .i_ready   (mem_ready),
        .o_timeout (w_timeout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = StFetch;
        w_illegal   = 1'b0;
        case (r_state)
            StFetch:    w_state_nxt = mem_ready ? StDecode : StFetch;
            StDecode: begin
                case (op)
                    OP_LW, OP_SW: w_state_nxt = StMemAdr;
                    OP_RTYPE:     w_state_nxt = StExecute;
                    OP_BEQ:       w_state_nxt = StBranch;
                    OP_J:         w_state_nxt = StJump;
`ifdef MC_ADDI_EN
                    OP_ADDI:      w_state_nxt = StAddiEx;
`endif
                    default:      w_illegal = 1'b1;
                endcase
            end
            StMemAdr:   w_state_nxt = (op == OP_SW) ? StMemWrite : StMemRead;
            StMemRead:  w_state_nxt = mem_ready ? StMemWb : StMemRead;
            StMemWrite: w_state_nxt = mem_ready ? StFetch : StMemWrite;
            StExecute:  w_state_nxt = StAluWb;
`ifdef MC_ADDI_EN
            StAddiEx:   w_state_nxt = StAddiWb;
`endif
            default:    w_state_nxt = StFetch;
        endcase
        // Timeout only fires with mem_ready low, so a same-cycle ready still advances.
        if (w_timeout) begin
            w_state_nxt = StFetch;
        end
    end

    always_comb begin
        IorD     = 1'b0;
        ALUSrcA  = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        ALUSrcB  = SRCB_REG;
        ALUOp    = ALUOP_ADD;
        PCSrc    = PCSRC_ALU;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        Branch   = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        case (r_state)
            StFetch: begin
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            StDecode:   ALUSrcB = SRCB_IMMSH;
            StMemAdr: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            StMemRead:  IorD = 1'b1;
            StMemWb: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            StMemWrite: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            StExecute: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            StAluWb: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            StBranch: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_SUB;
                PCSrc   = PCSRC_ALUOUT;
                Branch  = 1'b1;
            end
            StJump: begin
                PCSrc   = PCSRC_JUMP;
                PCWrite = 1'b1;
            end
`ifdef MC_ADDI_EN
            StAddiEx: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            StAddiWb:   RegWrite = 1'b1;
`endif
            default: ;
        endcase
        // Reset holds FETCH mux values but must not let mem_ready leak into the enables.
        if (reset) begin
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            Branch   = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
        end
    end

    assign mem_err    = w_timeout & ~reset;
    assign illegal_op = w_illegal & ~reset;
    assign state      = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: instruction-path reference model compared every cycle,
// plus directed traces with literal expectations; honours MC_ADDI_EN like the design.
module tb_mc_controller;

    localparam int unsigned TO = 16;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] BAD  = 6'b111111;

    typedef struct packed {
        logic       IorD;
        logic       ALUSrcA;
        logic       RegDst;
        logic       MemtoReg;
        logic [1:0] ALUSrcB;
        logic [1:0] ALUOp;
        logic [1:0] PCSrc;
        logic       IRWrite;
        logic       PCWrite;
        logic       Branch;
        logic       MemWrite;
        logic       RegWrite;
        logic       mem_err;
        logic       illegal_op;
        logic [3:0] state;
    } out_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mem_ready = 1'b1;
    logic [5:0] op = 6'b000000;
    logic       IorD, ALUSrcA, RegDst, MemtoReg;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic       IRWrite, PCWrite, Branch, MemWrite, RegWrite, mem_err, illegal_op;
    logic [3:0] state;
    out_t       dut_vec;

    int n_checks = 0;
    int n_pass   = 0;
    int m_state  = 0;
    int m_wait   = 0;
    int m_path[$];

    always #5 clk = ~clk;

    mc_controller #(
        .TIMEOUT (TO)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .mem_ready  (mem_ready),
        .IorD       (IorD),
        .ALUSrcA    (ALUSrcA),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .PCSrc      (PCSrc),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .Branch     (Branch),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .mem_err    (mem_err),
        .illegal_op (illegal_op),
        .state      (state)
    );

    assign dut_vec = {IorD, ALUSrcA, RegDst, MemtoReg, ALUSrcB, ALUOp, PCSrc,
                      IRWrite, PCWrite, Branch, MemWrite, RegWrite, mem_err, illegal_op, state};

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s at %0t: got 0x%0h, required 0x%0h", name, $time, act, req);
    endfunction

    function automatic bit is_legal(input logic [5:0] o);
        bit ok;
        ok = (o == LW) || (o == SW) || (o == RT) || (o == BEQ) || (o == JMP);
`ifdef MC_ADDI_EN
        ok = ok || (o == ADDI);
`endif
        return ok;
    endfunction

    // Remaining states an instruction visits after DECODE.
    task automatic load_path(input logic [5:0] o);
        m_path.delete();
        case (o)
            LW:      m_path = '{2, 3, 4};
            SW:      m_path = '{2, 5};
            RT:      m_path = '{6, 7};
            BEQ:     m_path = '{8};
            JMP:     m_path = '{11};
            default: if (o == ADDI && is_legal(o)) m_path = '{9, 10};
        endcase
    endtask

    task automatic model_reset();
        m_state = 0;
        m_wait  = 0;
        m_path.delete();
    endtask

    task automatic model_next();
        m_wait = 0;
        if (m_path.size() > 0) m_state = m_path.pop_front();
        else m_state = 0;
    endtask

    task automatic model_step();
        if (m_state == 1) begin
            load_path(op);
            model_next();
        end else if ((m_state == 0 || m_state == 3 || m_state == 5) && !mem_ready) begin
            m_wait++;
            if (m_wait == int'(TO)) model_reset();
        end else if (m_state == 0) begin
            m_wait  = 0;
            m_state = 1;
        end else begin
            model_next();
        end
    endtask

    function automatic out_t exp_out();
        out_t e;
        e = '0;
        e.state = 4'(m_state);
        case (m_state)
            0: begin e.ALUSrcB = 2'b01; e.IRWrite = mem_ready; e.PCWrite = mem_ready; end
            1: e.ALUSrcB = 2'b11;
            2, 9: begin e.ALUSrcA = 1'b1; e.ALUSrcB = 2'b10; end
            3: e.IorD = 1'b1;
            4: begin e.MemtoReg = 1'b1; e.RegWrite = 1'b1; end
            5: begin e.IorD = 1'b1; e.MemWrite = 1'b1; end
            6: begin e.ALUSrcA = 1'b1; e.ALUOp = 2'b10; end
            7: begin e.RegDst = 1'b1; e.RegWrite = 1'b1; end
            8: begin e.ALUSrcA = 1'b1; e.ALUOp = 2'b01; e.PCSrc = 2'b01; e.Branch = 1'b1; end
            10: e.RegWrite = 1'b1;
            11: begin e.PCSrc = 2'b10; e.PCWrite = 1'b1; end
            default: ;
        endcase
        if ((m_state == 0 || m_state == 3 || m_state == 5) && !mem_ready && (m_wait + 1 == int'(TO)))
            e.mem_err = 1'b1;
        if (m_state == 1 && !is_legal(op)) e.illegal_op = 1'b1;
        if (reset) begin
            e.IRWrite = 1'b0; e.PCWrite = 1'b0; e.Branch = 1'b0; e.MemWrite = 1'b0;
            e.RegWrite = 1'b0; e.mem_err = 1'b0; e.illegal_op = 1'b0;
        end
        return e;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        chk("cycle_outputs", 32'(dut_vec), 32'(exp_out()));
    end

    task automatic tick(input logic r, input logic [5:0] o, input logic rdy);
        @(posedge clk);
        #1;
        reset     = r;
        op        = o;
        mem_ready = rdy;
        @(negedge clk);
    endtask

    // n ticks with mem_ready=1, then one idle tick with mem_ready=0.
    task automatic trace_instr(input logic [5:0] o, input int n, output logic [31:0] tr,
                               output logic [7:0] ill, output logic [7:0] rm,
                               output logic [7:0] sb, output logic [7:0] we);
        tr = '0; ill = '0; rm = '0; sb = '0; we = '0;
        for (int i = 0; i <= n; i++) begin
            tick(1'b0, o, (i < n));
            tr  = {tr[27:0], state};
            ill = {ill[6:0], illegal_op};
            rm  = {rm[6:0], RegWrite & MemtoReg};
            sb  = {sb[6:0], ALUSrcB == 2'b10};
            we  = {we[6:0], IRWrite | PCWrite | MemWrite | RegWrite | Branch};
        end
    endtask

    initial begin
        int          errs, first, second, bad, mw, stall;
        logic [31:0] tr;
        logic [7:0]  ill, rm, sb, we;
        logic [5:0]  ro;
        logic        rr, rs;

        @(negedge clk);
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_irwrite_pcwrite", 32'({IRWrite, PCWrite}), 32'd0);
        chk("reset_alusrcb", 32'(ALUSrcB), 32'd1);

        trace_instr(LW, 5, tr, ill, rm, sb, we);
        chk("lw_states", tr, 32'h0001_2340);
        chk("lw_regwrite_memtoreg", 32'(rm), 32'h02);

        mw = 0; errs = 0;
        tick(1'b0, SW, 1'b1);
        tick(1'b0, SW, 1'b1);
        tick(1'b0, SW, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, SW, (i == 3));
            mw   += int'(MemWrite);
            errs += int'(mem_err);
        end
        tick(1'b0, SW, 1'b0);
        chk("sw_memwrite_cycles", 32'(mw), 32'd4);
        chk("sw_back_to_fetch", 32'(state), 32'd0);
        chk("sw_no_mem_err", 32'(errs), 32'd0);

        tick(1'b1, RT, 1'b0);
        errs = 0; first = 0; second = 0; bad = 0;
        for (int i = 1; i <= 32; i++) begin
            tick(1'b0, RT, 1'b0);
            if (state != 4'd0) bad++;
            if (mem_err) begin
                errs++;
                if (first == 0) first = i;
                else second = i;
            end
        end
        chk("fetch_timeout_pulses", 32'(errs), 32'd2);
        chk("fetch_timeout_first", 32'(first), 32'd16);
        chk("fetch_timeout_restart", 32'(second), 32'd32);
        chk("fetch_timeout_state_held", 32'(bad), 32'd0);

        errs = 0;
        for (int i = 1; i <= 16; i++) begin
            tick(1'b0, RT, (i == 16));
            errs += int'(mem_err);
        end
        chk("fetch_ready_wins_no_err", 32'(errs), 32'd0);
        trace_instr(RT, 3, tr, ill, rm, sb, we);
        chk("rtype_states_after_wait", tr, 32'h0000_1670);

        trace_instr(BAD, 2, tr, ill, rm, sb, we);
        chk("illegal_states", tr, 32'h0000_0010);
        chk("illegal_pulse_in_decode", 32'(ill), 32'h02);
        chk("illegal_no_write", 32'(we), 32'h04);

        trace_instr(BEQ, 3, tr, ill, rm, sb, we);
        chk("beq_states", tr, 32'h0000_0180);
        trace_instr(JMP, 3, tr, ill, rm, sb, we);
        chk("j_states", tr, 32'h0000_01b0);

`ifdef MC_ADDI_EN
        trace_instr(ADDI, 4, tr, ill, rm, sb, we);
        chk("addi_states", tr, 32'h0001_9a00 >> 4);
        chk("addi_alusrcb_imm", 32'(sb), 32'h04);
`else
        trace_instr(ADDI, 2, tr, ill, rm, sb, we);
        chk("addi_disabled_states", tr, 32'h0000_0010);
        chk("addi_disabled_illegal", 32'(ill), 32'h02);
`endif

        tick(1'b0, SW, 1'b1);
        tick(1'b0, SW, 1'b1);
        tick(1'b0, SW, 1'b1);
        tick(1'b0, SW, 1'b0);
        chk("midwrite_memwrite_before", 32'(MemWrite), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("midwrite_reset_state", 32'(state), 32'd0);
        chk("midwrite_reset_memwrite", 32'(MemWrite), 32'd0);
        tick(1'b1, SW, 1'b0);
        tick(1'b0, SW, 1'b1);
        chk("release_fetch_state", 32'(state), 32'd0);
        chk("release_fetch_writes", 32'({IRWrite, PCWrite}), 32'd3);
        tick(1'b0, SW, 1'b1);
        chk("release_decode", 32'(state), 32'd1);
        tick(1'b0, SW, 1'b1);
        tick(1'b0, SW, 1'b1);
        tick(1'b0, SW, 1'b0);

        stall = 0;
        ro = LW;
        for (int i = 0; i < 800; i++) begin
            if (m_state == 0) begin
                case ($urandom_range(0, 7))
                    0: ro = LW;
                    1: ro = SW;
                    2: ro = RT;
                    3: ro = BEQ;
                    4: ro = JMP;
                    5: ro = ADDI;
                    6: ro = 6'($urandom);
                    default: ro = SW;
                endcase
            end
            if (stall > 0) begin
                stall--;
                rr = 1'b0;
            end else begin
                rr = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 39) == 0) stall = int'($urandom_range(10, 40));
            end
            rs = ($urandom_range(0, 99) == 0);
            tick(rs, ro, rr);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
